// File: rtl/square_shift_add_if.sv
// Start/done handshake bundle for the shift-and-add squarer.
interface square_shift_add_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             done;
   logic             overflow;
   logic             busy;

   modport master (
      output start, x,
      input  y, done, overflow, busy
   );

   modport slave (
      input  start, x,
      output y, done, overflow, busy
   );
endinterface

// File: rtl/square_shift_add.sv
// Iterative squarer: |x|^2 over WIDTH shift-and-add steps, saturating to the
// positive signed range with an overflow flag.
module square_shift_add #(
   parameter int unsigned WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   square_shift_add_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_n;
   logic [2*WIDTH-1:0]   mcand, mcand_n;
   logic [2*WIDTH-1:0]   acc, acc_n;
   logic [WIDTH-1:0]     mplier, mplier_n;
   logic [WIDTH-1:0]     y_q, y_n;
   logic [WIDTH-1:0]     a;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 ov_q, ov_n;
   logic                 done_q, done_n;

   // Most negative input wraps to 2^(WIDTH-1), which is exactly its magnitude.
   always_comb a = bus.x[WIDTH-1] ? (~bus.x + 1'b1) : bus.x;

   always_comb begin
      state_n  = state;
      mcand_n  = mcand;
      acc_n    = acc;
      mplier_n = mplier;
      cnt_n    = cnt;
      y_n      = y_q;
      ov_n     = ov_q;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               mcand_n  = {{WIDTH{1'b0}}, a};
               mplier_n = a;
               acc_n    = '0;
               cnt_n    = '0;
               state_n  = RUN;
            end
         end
         RUN: begin
            // The cycle after the last step only resolves saturation.
            if (cnt == CW'(WIDTH)) begin
               ov_n    = |acc[2*WIDTH-1:WIDTH-1];
               y_n     = ov_n ? {1'b0, {(WIDTH-1){1'b1}}} : acc[WIDTH-1:0];
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               if (mplier[0]) acc_n = acc + mcand;
               mcand_n  = mcand << 1;
               mplier_n = mplier >> 1;
               cnt_n    = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
         y_q    <= '0;
         ov_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         mcand  <= mcand_n;
         acc    <= acc_n;
         mplier <= mplier_n;
         cnt    <= cnt_n;
         y_q    <= y_n;
         ov_q   <= ov_n;
         done_q <= done_n;
      end
   end

   assign bus.y        = y_q;
   assign bus.done     = done_q;
   assign bus.overflow = ov_q;
   assign bus.busy     = (state == RUN);
endmodule

// File: tb/tb_square_shift_add.sv
// Scoreboard bench for square_shift_add: a cycle-level handshake model pushes
// expected squares; a separate monitor pops them on each done pulse.
module tb_square_shift_add;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   square_shift_add_if #(.WIDTH(W)) bus ();
   square_shift_add #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [W-1:0]    x;
      longint unsigned y;
      logic            ov;
      int unsigned     acc_cyc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_rst  = 1'b1;
   int unsigned m_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint unsigned mag(logic [W-1:0] v);
      longint sx;
      sx = longint'($signed(v));
      return (sx < 0) ? longint'(-sx) : longint'(sx);
   endfunction

   function automatic exp_t model(logic [W-1:0] v, int unsigned c);
      exp_t            e;
      longint unsigned sq;
      sq        = mag(v) * mag(v);
      e.x       = v;
      e.ov      = (sq >= (64'd1 << (W-1)));
      e.y       = e.ov ? ((64'd1 << (W-1)) - 64'd1) : sq;
      e.acc_cyc = c;
      return e;
   endfunction

   function automatic longint unsigned isqrt(longint unsigned v);
      longint unsigned r, t;
      r = 0;
      for (int b = 31; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Handshake model: compare against the state after the last edge, then
   // predict what the coming edge does with the inputs now applied.
   always @(negedge clk) begin
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("done", 64'(bus.done), 64'(m_done));
      if (m_rst) begin
         chk("reset_y", 64'(bus.y), 0);
         chk("reset_overflow", 64'(bus.overflow), 0);
      end
      if (!rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_rst  = 1'b1;
         q.delete();
      end else begin
         m_rst  = 1'b0;
         m_done = 1'b0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            q.push_back(model(bus.x, cyc + 1));
            m_busy = 1'b1;
            m_cnt  = W + 1;
         end
      end
   end

   // Result monitor.
   always @(negedge clk) begin
      exp_t            e;
      longint unsigned r, a;
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("y", 64'(bus.y), e.y);
            chk("overflow", 64'(bus.overflow), 64'(e.ov));
            chk("latency", 64'(cyc - e.acc_cyc), 64'(W + 1));
            if (!e.ov) begin
               r = isqrt(64'(bus.y));
               a = mag(e.x);
               chk("round_trip", 64'((r + 1 >= a) && (r <= a + 1)), 1);
            end
         end
      end
   end

   task automatic op(input logic [W-1:0] v);
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.x = v;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.x = $urandom;
   endtask

   task automatic settle();
      repeat (W + 3) @(posedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.x     = '0;
      rst       = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (40) @(posedge clk);

      op(0);               settle();
      op(1);               settle();
      op(46340);           settle();
      op(-32'sd5);         settle();
      op(46341);           settle();
      op(32'h8000_0000);   settle();

      // Starts while busy are ignored; a start in the done cycle is accepted.
      op(7);
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1; bus.x = 9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1 bus.start = 1'b1; bus.x = 9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (13) @(posedge clk);
      #1 bus.start = 1'b1; bus.x = 3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      settle();

      op(1000);
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (40) @(posedge clk);
      op(12);              settle();

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1 bus.start = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       bus.x = $urandom;
            1:       bus.x = -W'($urandom_range(0, 50000));
            default: bus.x = W'($urandom_range(0, 46340));
         endcase
      end
      #1 bus.start = 1'b0;
      settle();

      chk("pending", 64'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
